// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the PC register and sequences instruction fetch for the IF stage.
//   The block keeps at most one instruction-memory request outstanding and
//   tolerates any memory latency. Fetched words are presented to the IF/ID
//   boundary. A one-entry skid buffer absorbs a word that returns while ID
//   is stalled. Redirects from EX restart fetch at the new target and
//   squash any in-flight word.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active low (0 = reset)
//   stall          hazard unit hold of the IF/ID outputs
//   redirect_valid single-cycle redirect pulse from EX
//   redirect_pc    redirect target (low two bits ignored)
//   imem_req       fetch request, held until imem_ack
//   imem_addr      fetch address, word aligned, stable while imem_req=1
//   imem_ack       memory accepted the request; imem_rdata valid this cycle
//   imem_rdata     fetched instruction word
//   pc             next address to fetch
//   if_valid       if_instr/if_pc hold a valid instruction
//   if_instr       instruction to ID
//   if_pc          PC of if_instr
module fetch_sequencer #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             INC      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [N-1:0] pc,
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [N-1:0] if_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] KILL = 2'd2;
    localparam logic [1:0] FULL = 2'd3;

    function automatic logic [N-1:0] align_pc(input logic [N-1:0] a);
        return a & ~N'(3);
    endfunction

    // Wraps modulo 2^N by construction of the N-bit sum.
    function automatic logic [N-1:0] step_pc(input logic [N-1:0] a);
        return a + N'(INC);
    endfunction

    localparam logic [N-1:0] RESET_AL = RESET_PC & ~N'(3);

    logic [1:0]   state;
    logic [31:0]  skid_instr;
    logic [N-1:0] skid_pc;
    logic [N-1:0] pc_next;

    assign pc_next = step_pc(pc);

    // The skid buffer is occupied exactly when state == FULL, so leaving
    // FULL (on a redirect or a drained stall) is what empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_AL;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_AL;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            if_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
                // Request still owned by memory: keep it asserted with the
                // old address and throw its data away when it returns.
                state <= KILL;
            end else begin
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= align_pc(redirect_pc);
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc        <= pc_next;
                        imem_addr <= pc_next;
                        if (!if_valid || !stall) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            imem_req   <= 1'b0;
                            state      <= FULL;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state     <= REQ;
                        imem_addr <= pc;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        if_valid  <= 1'b1;
                        if_instr  <= skid_instr;
                        if_pc     <= skid_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        state     <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    fetch_sequencer #(.N(32), .RESET_PC(32'h0), .INC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of directed stimulus and the outputs required after that edge.
    // fa is the fetch address whose word is returned when ack=1.
    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] fa;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ifpc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic ack, input logic [31:0] fa,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_ifpc,
                                input logic [31:0] e_pc);
        vec_t v;
        v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = ack; v.fa = fa;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_ifpc = e_ifpc; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, " pc"},       pc,               32'h0);
        check({tag, " imem_req"}, 32'(imem_req),    32'h0);
        check({tag, " imem_addr"},imem_addr,        32'h0);
        check({tag, " if_valid"}, 32'(if_valid),    32'h0);
        check({tag, " if_instr"}, if_instr,         32'h0);
        check({tag, " if_pc"},    if_pc,            32'h0);
    endtask

    // Reference-model state for the random phase
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    logic        s, r, a;
    logic [31:0] rp;
    int          idle_cycles;
    int          deliveries;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        // ---- reset held with random inputs ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stall          = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = $urandom();
            imem_ack       = 1'($urandom_range(0, 1));
            imem_rdata     = $urandom();
            @(posedge clk); #1;
            check_reset_vals($sformatf("rst%0d", i));
        end

        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
        reset = 1'b1;
        #1 check("release req", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        check("first req",  32'(imem_req), 32'h1);
        check("first addr", imem_addr,      32'h0);
        check("first pc",   pc,             32'h0);
        check("first vld",  32'(if_valid),  32'h0);

        // ---- directed vector table ----
        vt.push_back(mk(0,0,0,        1,0,          1,4,          1,0,          4));
        vt.push_back(mk(0,0,0,        1,4,          1,8,          1,4,          8));
        vt.push_back(mk(0,0,0,        1,8,          1,12,         1,8,          12));
        vt.push_back(mk(0,0,0,        1,12,         1,16,         1,12,         16));
        vt.push_back(mk(0,0,0,        0,0,          1,16,         0,0,          16));
        vt.push_back(mk(0,0,0,        0,0,          1,16,         0,0,          16));
        vt.push_back(mk(0,0,0,        1,16,         1,20,         1,16,         20));
        vt.push_back(mk(0,0,0,        0,0,          1,20,         0,0,          20));
        vt.push_back(mk(0,0,0,        0,0,          1,20,         0,0,          20));
        vt.push_back(mk(0,0,0,        1,20,         1,24,         1,20,         24));
        vt.push_back(mk(1,0,0,        1,24,         0,0,          1,20,         28));
        vt.push_back(mk(1,0,0,        0,0,          0,0,          1,20,         28));
        vt.push_back(mk(0,0,0,        0,0,          1,28,         1,24,         28));
        vt.push_back(mk(0,0,0,        0,0,          1,28,         0,0,          28));
        vt.push_back(mk(0,1,'h200,    0,0,          1,28,         0,0,          'h200));
        vt.push_back(mk(0,0,0,        0,0,          1,28,         0,0,          'h200));
        vt.push_back(mk(0,0,0,        1,28,         1,'h200,      0,0,          'h200));
        vt.push_back(mk(0,0,0,        1,'h200,      1,'h204,      1,'h200,      'h204));
        vt.push_back(mk(0,1,'h303,    1,'h204,      1,'h300,      0,0,          'h300));
        vt.push_back(mk(0,0,0,        1,'h300,      1,'h304,      1,'h300,      'h304));
        vt.push_back(mk(1,0,0,        1,'h304,      0,0,          1,'h300,      'h308));
        vt.push_back(mk(1,1,'h400,    0,0,          1,'h400,      0,0,          'h400));
        vt.push_back(mk(1,0,0,        0,0,          1,'h400,      0,0,          'h400));
        vt.push_back(mk(0,0,0,        1,'h400,      1,'h404,      1,'h400,      'h404));
        vt.push_back(mk(0,1,'h500,    0,0,          1,'h404,      0,0,          'h500));
        vt.push_back(mk(0,1,'h600,    0,0,          1,'h404,      0,0,          'h600));
        vt.push_back(mk(0,0,0,        1,'h404,      1,'h600,      0,0,          'h600));
        vt.push_back(mk(0,0,0,        1,'h600,      1,'h604,      1,'h600,      'h604));
        vt.push_back(mk(0,1,'hFFFFFFFC,1,'h604,     1,'hFFFFFFFC, 0,0,          'hFFFFFFFC));
        vt.push_back(mk(0,0,0,        1,'hFFFFFFFC, 1,0,          1,'hFFFFFFFC, 0));
        vt.push_back(mk(0,0,0,        1,0,          1,4,          1,0,          4));
        vt.push_back(mk(0,0,0,        1,4,          1,8,          1,4,          8));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            stall          = vt[i].stall;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            imem_ack       = vt[i].ack;
            imem_rdata     = vt[i].ack ? (vt[i].fa ^ KEY) : 32'hDEADBEEF;
            @(posedge clk); #1;
            check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
            if (vt[i].e_req)
                check($sformatf("row%0d imem_addr", i), imem_addr, vt[i].e_addr);
            check($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(vt[i].e_vld));
            if (vt[i].e_vld) begin
                check($sformatf("row%0d if_pc", i),    if_pc,    vt[i].e_ifpc);
                check($sformatf("row%0d if_instr", i), if_instr, vt[i].e_ifpc ^ KEY);
            end
            check($sformatf("row%0d pc", i), pc, vt[i].e_pc);
        end

        // ---- asynchronous reset between clock edges, mid-request ----
        #2 reset = 1'b0;
        #1 check_reset_vals("async");
        stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("async hold");
        @(negedge clk);
        reset = 1'b1;

        // ---- randomized run against the reference model ----
        exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        idle_cycles = 0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                check("proto req held",  32'(imem_req), 32'h1);
                check("proto addr held", imem_addr,     prev_addr);
            end
            if (imem_req)
                check("addr aligned", 32'(imem_addr[1:0]), 32'h0);

            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 24) == 0);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom();
            a  = imem_req && ($urandom_range(0, 2) == 0);

            stall = s; redirect_valid = r; redirect_pc = rp;
            imem_ack = a; imem_rdata = a ? (imem_addr ^ KEY) : $urandom();

            if (r) begin
                exp_pc = rp & ~32'h3;
                idle_cycles = 0;
            end else if (if_valid && !s) begin
                check("stream if_pc", if_pc, exp_pc);
                check("stream if_instr", if_instr, exp_pc ^ KEY);
                exp_pc = if_pc + 32'd4;
                deliveries++;
                idle_cycles = 0;
            end else begin
                idle_cycles++;
                if (idle_cycles > 80) begin
                    check("progress within 80 cycles", 32'(idle_cycles), 32'd80);
                    idle_cycles = 0;
                end
            end

            prev_req = imem_req; prev_ack = a; prev_addr = imem_addr;
        end
        check("deliveries at least 200", 32'(deliveries >= 200), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Drives the PC register and sequences instruction fetch for the IF stage. It issues one instruction-memory request at a time and tolerates variable memory latency. It delivers a fetched instruction and its PC to the IF/ID boundary, honours pipeline stalls through a one-entry skid buffer, and handles branch/jump redirects from EX, including discarding an in-flight fetch.

Parameters:
N, 32, PC/address width in bits
RESET_PC, 0, PC value loaded on reset
INC, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
stall  input  1  hazard unit: hold IF/ID outputs
redirect_valid  input  1  EX redirect pulse, one cycle
redirect_pc  input  N  redirect target
imem_req  output  1  fetch request
imem_addr  output  N  fetch address, stable while imem_req=1 until ack
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
pc  output  N  current PC register value (next address to fetch)
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  32  instruction to ID
if_pc  output  N  PC of if_instr

Behaviour:
- Reset (reset=0, async): pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_instr=0; if_pc=0; skid empty; state=IDLE.
- States: IDLE, REQ, KILL, FULL. All outputs registered.
- IDLE: first edge after reset release -> REQ; imem_req=1, imem_addr=pc.
- REQ: imem_req=1, imem_addr=pc held until imem_ack. On ack with no redirect:
  - Slot free (if_valid=0 or stall=0): next cycle if_valid=1, if_instr=imem_rdata, if_pc=pc. pc <= pc+INC, modulo 2^N (0xFFFFFFFC+4 -> 0). Stay in REQ; the next request is issued at the new pc the following cycle. Back-to-back fetches are one per cycle with 1-cycle ack.
  - Slot occupied and stall=1: write data and PC to the skid buffer; pc <= pc+INC; -> FULL; imem_req=0.
- Stall with no ack: if_valid, if_instr and if_pc hold. When stall=0 and no new data arrives, if_valid<=0 next cycle (the instruction is consumed).
- FULL: imem_req=0. When stall drops, skid contents move to if_* next cycle, the skid empties, and the state -> REQ.
- Redirect (highest priority, any state), next cycle:
  - pc <= {redirect_pc[N-1:2],2'b00}.
  - if_valid <= 0 and the skid is cleared, regardless of stall.
  - If a request is outstanding without ack in the same cycle -> KILL.
  - Otherwise (IDLE, FULL, or ack in the same cycle, whose data is discarded) -> REQ at the new pc.
- KILL: imem_req stays 1 with the old address until imem_ack. That ack's data is discarded and if_valid stays 0. Then -> REQ at the redirected pc. A further redirect while in KILL updates pc and the state remains KILL.
- A reset during any state aborts immediately to the reset values. Memory side effects are not undone.
- imem_addr low 2 bits are always 0.

Test Plan:
- Reset values: hold reset=0 with random inputs -> pc=0, imem_req=0, if_valid=0, if_instr=0. Release -> imem_req=1, imem_addr=0 one cycle later.
- Streaming: ack every cycle with rdata = addr^0xA5A5A5A5 -> if_pc sequence 0,4,8,12 with matching if_instr, one per cycle. With a 3-cycle ack latency, imem_addr stays stable until ack and if_valid pulses every 3 cycles.
- Stall/skid: stall=1 while if_pc=4 is valid, ack for 8 arrives -> if_pc holds 4, FULL, imem_req=0. Drop stall -> if_pc=8 next cycle, then a request at 12.
- Redirect mid-fetch: request at 0x10 pending, redirect to 0x200 -> KILL. The ack for 0x10 is discarded (if_valid stays 0), the next request is at 0x200, then if_pc=0x200. A redirect to 0x203 -> fetch at 0x200.
- Redirect coincident with ack, and with stall+FULL -> data discarded, skid cleared, if_valid=0, next request at the redirect target.
- Wrap and async reset: pc=0xFFFFFFFC fetched -> next fetch at 0x00000000. Assert reset mid-REQ (between clock edges) -> outputs reset immediately, without waiting for clk.
